// File: rtl/vga_frame_capture_if.sv
// VGA pixel stream observed by the frame capture monitor, plus the capture results it reports.
interface vga_frame_capture_if #(
  parameter int unsigned CW = 8,
  parameter int unsigned XW = 10,
  parameter int unsigned YW = 10
);
  // Observed VGA pins
  logic            pix_en;
  logic            hsync;
  logic            vsync;
  logic            blank_b;
  logic [CW-1:0]   r;
  logic [CW-1:0]   g;
  logic [CW-1:0]   b;
  // Capture results
  logic            px_valid;
  logic [XW-1:0]   px_x;
  logic [YW-1:0]   px_y;
  logic [3*CW-1:0] px_rgb;
  logic            frame_done;
  logic [31:0]     frame_sum;
  logic            line_err;
  logic            frame_err;
  logic            locked;

  // Stream source side
  modport master (
    output pix_en, hsync, vsync, blank_b, r, g, b,
    input  px_valid, px_x, px_y, px_rgb, frame_done, frame_sum, line_err, frame_err, locked
  );

  // Capture monitor side
  modport slave (
    input  pix_en, hsync, vsync, blank_b, r, g, b,
    output px_valid, px_x, px_y, px_rgb, frame_done, frame_sum, line_err, frame_err, locked
  );
endinterface

// File: rtl/vga_frame_capture.sv
// Receive-side VGA monitor: recovers pixel coordinates from sync/blank edges, emits one
// registered write per active pixel, checks line/frame geometry and checksums each frame.
module vga_frame_capture #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned CW       = 8,
  parameter int unsigned XW       = 10,
  parameter int unsigned YW       = 10
) (
  input logic                clk,
  input logic                reset,
  vga_frame_capture_if.slave vif
);

  localparam logic [XW-1:0] HMax = XW'(H_ACTIVE);
  localparam logic [YW-1:0] VMax = YW'(V_ACTIVE);

  typedef enum logic [1:0] {StHunt, StVsync, StFrame} state_e;

  state_e          state_q, state_d;
  logic            vs_prev_q, vs_prev_d;
  logic            bl_prev_q, bl_prev_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [31:0]     sum_q, sum_d;
  logic            frame_bad_q, frame_bad_d;
  logic            px_valid_q, px_valid_d;
  logic [XW-1:0]   px_x_q, px_x_d;
  logic [YW-1:0]   px_y_q, px_y_d;
  logic [3*CW-1:0] px_rgb_q, px_rgb_d;
  logic            frame_done_q, frame_done_d;
  logic [31:0]     frame_sum_q, frame_sum_d;
  logic            line_err_q, line_err_d;
  logic            frame_err_q, frame_err_d;
  logic            locked_q, locked_d;

  logic [3*CW-1:0] rgb;
  logic            vs_fall, vs_rise, bl_fall;
  logic            line_bad, geom_bad;

  assign rgb     = {vif.r, vif.g, vif.b};
  // Edges are between consecutive enabled samples, so compare against the last sampled level
  assign vs_fall = vs_prev_q & ~vif.vsync;
  assign vs_rise = ~vs_prev_q & vif.vsync;
  assign bl_fall = bl_prev_q & ~vif.blank_b;

  // Next-state: sync hunting, pixel capture, geometry checks and checksum
  always_comb begin
    state_d      = state_q;
    vs_prev_d    = vs_prev_q;
    bl_prev_d    = bl_prev_q;
    x_d          = x_q;
    y_d          = y_q;
    sum_d        = sum_q;
    frame_bad_d  = frame_bad_q;
    px_valid_d   = 1'b0;
    px_x_d       = px_x_q;
    px_y_d       = px_y_q;
    px_rgb_d     = px_rgb_q;
    frame_done_d = 1'b0;
    frame_sum_d  = frame_sum_q;
    line_err_d   = line_err_q;
    frame_err_d  = frame_err_q;
    locked_d     = locked_q;
    line_bad     = 1'b0;
    geom_bad     = 1'b0;

    if (vif.pix_en) begin
      vs_prev_d = vif.vsync;
      bl_prev_d = vif.blank_b;
      case (state_q)
        StHunt: begin
          if (vs_fall) state_d = StVsync;
        end
        StVsync: begin
          if (vs_rise) begin
            x_d         = '0;
            y_d         = '0;
            sum_d       = '0;
            frame_bad_d = 1'b0;
            state_d     = StFrame;
          end
        end
        StFrame: begin
          if (vif.blank_b) begin
            if ((x_q < HMax) && (y_q < VMax)) begin
              px_valid_d = 1'b1;
              px_x_d     = x_q;
              px_y_d     = y_q;
              px_rgb_d   = rgb;
            end
            // Overlong lines still contribute to the checksum
            sum_d = sum_q + 32'(rgb);
            if (x_q != '1) x_d = x_q + XW'(1);
            if (!vif.hsync) line_bad = 1'b1;
          end
          // End of line is handled before end of frame so its y step counts
          if (bl_fall) begin
            if (x_q != HMax) line_bad = 1'b1;
            x_d = '0;
            if (y_q != '1) y_d = y_q + YW'(1);
          end
          if (line_bad) line_err_d = 1'b1;
          if (vs_fall) begin
            geom_bad = (y_d != VMax);
            if (geom_bad) frame_err_d = 1'b1;
            frame_sum_d  = sum_d;
            frame_done_d = 1'b1;
            locked_d     = ~(frame_bad_q | line_bad | geom_bad);
            state_d      = StVsync;
          end
          frame_bad_d = frame_bad_q | line_bad | geom_bad;
        end
        default: state_d = StHunt;
      endcase
    end
  end

  // State and output registers; reset discards any partial frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StHunt;
      vs_prev_q    <= 1'b0;
      bl_prev_q    <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      sum_q        <= '0;
      frame_bad_q  <= 1'b0;
      px_valid_q   <= 1'b0;
      px_x_q       <= '0;
      px_y_q       <= '0;
      px_rgb_q     <= '0;
      frame_done_q <= 1'b0;
      frame_sum_q  <= '0;
      line_err_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      vs_prev_q    <= vs_prev_d;
      bl_prev_q    <= bl_prev_d;
      x_q          <= x_d;
      y_q          <= y_d;
      sum_q        <= sum_d;
      frame_bad_q  <= frame_bad_d;
      px_valid_q   <= px_valid_d;
      px_x_q       <= px_x_d;
      px_y_q       <= px_y_d;
      px_rgb_q     <= px_rgb_d;
      frame_done_q <= frame_done_d;
      frame_sum_q  <= frame_sum_d;
      line_err_q   <= line_err_d;
      frame_err_q  <= frame_err_d;
      locked_q     <= locked_d;
    end
  end

  assign vif.px_valid   = px_valid_q;
  assign vif.px_x       = px_x_q;
  assign vif.px_y       = px_y_q;
  assign vif.px_rgb     = px_rgb_q;
  assign vif.frame_done = frame_done_q;
  assign vif.frame_sum  = frame_sum_q;
  assign vif.line_err   = line_err_q;
  assign vif.frame_err  = frame_err_q;
  assign vif.locked     = locked_q;

endmodule

// File: tb/tb_vga_frame_capture.sv
// Directed bench for vga_frame_capture with a 4x3 active area.
module tb_vga_frame_capture;
  localparam int unsigned H = 4;
  localparam int unsigned V = 3;
  // r sits at bits 23:16 of {r,g,b}, so a full 4x3 frame of r=x+4y sums to 66<<16
  localparam logic [31:0] Sum66 = 32'd66 << 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  vga_frame_capture_if #(.CW(8), .XW(10), .YW(10)) vif ();

  vga_frame_capture #(
    .H_ACTIVE(H),
    .V_ACTIVE(V),
    .CW      (8),
    .XW      (10),
    .YW      (10)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .vif  (vif)
  );

  always #5 clk = ~clk;

  int          tests  = 0;
  int          fails  = 0;
  int          div    = 1;
  int          seen   = 0;
  logic [31:0] last_x = 0;

  // Independent count of write strobes seen by the bench
  always @(negedge clk) if (vif.px_valid === 1'b1) seen++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic pe, input logic hs, input logic vs, input logic bl,
                       input logic [7:0] rv);
    vif.pix_en  = pe;
    vif.hsync   = hs;
    vif.vsync   = vs;
    vif.blank_b = bl;
    vif.r       = rv;
    vif.g       = 8'd0;
    vif.b       = 8'd0;
  endtask

  // One enabled sample, preceded by div-1 disabled clocks during which strobes must stay low
  task automatic sample(input logic hs, input logic vs, input logic bl, input logic [7:0] rv);
    for (int k = 1; k < div; k++) begin
      drive(1'b0, hs, vs, bl, rv);
      @(negedge clk);
      chk("idle_px_valid", vif.px_valid, 0);
      chk("idle_frame_done", vif.frame_done, 0);
      chk("idle_px_x_hold", vif.px_x, last_x);
    end
    drive(1'b1, hs, vs, bl, rv);
    @(negedge clk);
  endtask

  task automatic send_line(input int y, input int npix);
    sample(1'b0, 1'b1, 1'b0, 8'd0);
    chk("hsync_px_valid", vif.px_valid, 0);
    sample(1'b1, 1'b1, 1'b0, 8'd0);
    for (int i = 0; i < npix; i++) begin
      sample(1'b1, 1'b1, 1'b1, 8'(i + 4 * y));
      if (i < H && y < V) begin
        chk("px_valid", vif.px_valid, 1);
        chk("px_x", vif.px_x, i);
        chk("px_y", vif.px_y, y);
        chk("px_rgb", vif.px_rgb, (i + 4 * y) << 16);
        last_x = i;
      end else begin
        chk("px_valid_overlong", vif.px_valid, 0);
      end
    end
    sample(1'b1, 1'b1, 1'b0, 8'd0);
    chk("eol_px_valid", vif.px_valid, 0);
  endtask

  task automatic send_frame(input int nlines, input int long_line, input int exp_writes);
    seen = 0;
    for (int y = 0; y < nlines; y++) send_line(y, (y == long_line) ? 5 : 4);
    chk("writes_per_frame", seen, exp_writes);
  endtask

  task automatic vsync_pulse(input logic exp_done, input logic [31:0] exp_sum,
                             input logic exp_locked, input logic exp_lerr, input logic exp_ferr);
    sample(1'b1, 1'b0, 1'b0, 8'd0);
    chk("frame_done", vif.frame_done, exp_done);
    chk("frame_sum", vif.frame_sum, exp_sum);
    chk("locked", vif.locked, exp_locked);
    chk("line_err", vif.line_err, exp_lerr);
    chk("frame_err", vif.frame_err, exp_ferr);
    sample(1'b1, 1'b0, 1'b0, 8'd0);
    chk("frame_done_one_clk", vif.frame_done, 0);
    sample(1'b1, 1'b1, 1'b0, 8'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_px_valid"}, vif.px_valid, 0);
    chk({tag, "_px_x"}, vif.px_x, 0);
    chk({tag, "_px_y"}, vif.px_y, 0);
    chk({tag, "_px_rgb"}, vif.px_rgb, 0);
    chk({tag, "_frame_done"}, vif.frame_done, 0);
    chk({tag, "_frame_sum"}, vif.frame_sum, 0);
    chk({tag, "_line_err"}, vif.line_err, 0);
    chk({tag, "_frame_err"}, vif.frame_err, 0);
    chk({tag, "_locked"}, vif.locked, 0);
  endtask

  initial begin
    // 1: reset, idle, and active-looking pixels before any vsync are ignored
    drive(1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
    #12;
    chk_all_zero("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    sample(1'b1, 1'b1, 1'b0, 8'd0);
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      sample(1'b1, 1'b1, 1'b1, 8'(i + 1));
      chk("hunt_px_valid", vif.px_valid, 0);
    end
    sample(1'b1, 1'b1, 1'b0, 8'd0);
    chk_all_zero("after_reset");
    chk("hunt_writes", seen, 0);

    // 2: two clean frames
    vsync_pulse(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    send_frame(3, -1, 12);
    vsync_pulse(1'b1, Sum66, 1'b1, 1'b0, 1'b0);
    send_frame(3, -1, 12);
    vsync_pulse(1'b1, Sum66, 1'b1, 1'b0, 1'b0);

    // 3: line 1 has five pixels; the fifth (r=8) is summed but not written
    send_frame(3, 1, 12);
    vsync_pulse(1'b1, Sum66 + (32'd8 << 16), 1'b0, 1'b1, 1'b0);
    send_frame(3, -1, 12);
    vsync_pulse(1'b1, Sum66, 1'b1, 1'b1, 1'b0);

    // 4: frame with only two lines (r values 0..7 sum to 28)
    send_frame(2, -1, 8);
    vsync_pulse(1'b1, 32'd28 << 16, 1'b0, 1'b1, 1'b1);

    // 5: pixel strobe every third clock
    div = 3;
    send_frame(3, -1, 12);
    vsync_pulse(1'b1, Sum66, 1'b1, 1'b1, 1'b1);
    div = 1;

    // 6: asynchronous reset in the middle of line 2
    send_line(0, 4);
    send_line(1, 4);
    sample(1'b0, 1'b1, 1'b0, 8'd0);
    sample(1'b1, 1'b1, 1'b0, 8'd0);
    sample(1'b1, 1'b1, 1'b1, 8'd8);
    sample(1'b1, 1'b1, 1'b1, 8'd9);
    chk("pre_reset_px_x", vif.px_x, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    @(negedge clk);
    rst_n  = 1'b1;
    last_x = 0;
    sample(1'b1, 1'b1, 1'b0, 8'd0);
    vsync_pulse(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    send_frame(3, -1, 12);
    vsync_pulse(1'b1, Sum66, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
